// File: rtl/rw_feature_packer.sv
// rw_feature_packer: serial-to-parallel front end for the red-wine classifier.
// Packs one frame of quantised features into inp, lets it settle, then flags it.
module rw_feature_packer #(
    parameter int WIDTH_A = 4,
    parameter int NUM_A   = 11,
    parameter int SETTLE  = 4,
    parameter int CNTW    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH_A-1:0]         in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [NUM_A*WIDTH_A-1:0]   inp,
    output logic                       inp_valid,
    input  logic                       inp_ack,
    output logic                       frame_err,
    output logic [CNTW-1:0]            frame_cnt
);

    localparam int IW = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam int VW = NUM_A * WIDTH_A;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_A - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SETTLE_ST = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t            state;
    logic [IW-1:0]     idx;
    logic [7:0]        scnt;
    logic [VW-1:0]     stage;
    logic [VW-1:0]     stage_nx;
    logic              xfer;

    assign xfer = in_valid & in_ready;

    // Staging register with the current beat merged into its slot
    always_comb begin
        stage_nx = stage;
        for (int i = 0; i < NUM_A; i++) begin
            if (idx == IW'(i)) begin
                stage_nx[i*WIDTH_A +: WIDTH_A] = in_data;
            end
        end
    end

    // Frame assembly, settle timing and consumer handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            idx       <= '0;
            scnt      <= '0;
            stage     <= '0;
            inp       <= '0;
            inp_valid <= 1'b0;
            in_ready  <= 1'b1;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                FILL: begin
                    if (xfer) begin
                        stage <= stage_nx;
                        if (idx == LAST_IDX) begin
                            inp       <= stage_nx;
                            idx       <= '0;
                            frame_cnt <= frame_cnt + 1'b1;
                            scnt      <= '0;
                            state     <= SETTLE_ST;
                            in_ready  <= 1'b0;
                            frame_err <= ~in_last;
                        end else if (in_last) begin
                            idx       <= '0;
                            frame_err <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                SETTLE_ST: begin
                    if (scnt == SETTLE_LAST) begin
                        state     <= HOLD;
                        inp_valid <= 1'b1;
                    end else begin
                        scnt <= scnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (inp_ack) begin
                        state     <= FILL;
                        inp_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= FILL;
                    inp_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
